// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter sharing one 128-bit line-fill/write-back memory port.
// Latency: request sampled at edge N -> arb2mem_valid from N+1; memory ready at M -> client ready at M+1.
// Backpressure: a client holds valid until its ready pulse; one transaction in flight, watchdog aborts stalls.
//
// Ports:
//   clk, r (async active-low reset)
//   c0_*/c1_* : client request (valid, rw, addr, wdata) and response (rdata, ready, err)
//   arb2mem_* : registered memory request (valid, rw, addr, data)
//   mem2arb_* : memory response (data, ready)
//   busy      : high while a transaction is in ISSUE or DONE
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         r,
    input  logic         c0_valid,
    input  logic         c0_rw,
    input  logic [31:0]  c0_addr,
    input  logic [127:0] c0_wdata,
    output logic [127:0] c0_rdata,
    output logic         c0_ready,
    output logic         c0_err,
    input  logic         c1_valid,
    input  logic         c1_rw,
    input  logic [31:0]  c1_addr,
    input  logic [127:0] c1_wdata,
    output logic [127:0] c1_rdata,
    output logic         c1_ready,
    output logic         c1_err,
    output logic         arb2mem_valid,
    output logic         arb2mem_rw,
    output logic [31:0]  arb2mem_addr,
    output logic [127:0] arb2mem_data,
    input  logic [127:0] mem2arb_data,
    input  logic         mem2arb_ready,
    output logic         busy
);

    // Counter holds 0..TIMEOUT; a disabled watchdog still keeps a 1-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_grant;
    logic           r_last_grant;
    logic           r_rw;
    logic [31:0]    r_addr;
    logic [127:0]   r_wdata;
    logic [127:0]   r_resp;
    logic [CW-1:0]  r_cnt;
    logic           r_mem_vld;
    logic           r_busy;
    logic           r_c0_ready;
    logic           r_c1_ready;
    logic           r_c0_err;
    logic           r_c1_err;

    logic           w_any_req;
    logic           w_pick_c1;
    logic           w_timeout;

    always_comb begin
        w_any_req = c0_valid | c1_valid;
        // On a tie the client that was not served last wins.
        w_pick_c1 = c1_valid & (~c0_valid | ~r_last_grant);
        w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp       <= '0;
            r_cnt        <= '0;
            r_mem_vld    <= 1'b0;
            r_busy       <= 1'b0;
            r_c0_ready   <= 1'b0;
            r_c1_ready   <= 1'b0;
            r_c0_err     <= 1'b0;
            r_c1_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_pick_c1;
                        r_rw      <= w_pick_c1 ? c1_rw    : c0_rw;
                        r_addr    <= w_pick_c1 ? c1_addr  : c0_addr;
                        r_wdata   <= w_pick_c1 ? c1_wdata : c0_wdata;
                        r_cnt     <= '0;
                        r_mem_vld <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Memory completion takes priority over a simultaneous timeout.
                    if (mem2arb_ready) begin
                        r_resp     <= mem2arb_data;
                        r_c0_ready <= ~r_grant;
                        r_c1_ready <= r_grant;
                        r_c0_err   <= 1'b0;
                        r_c1_err   <= 1'b0;
                        r_mem_vld  <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (w_timeout) begin
                        r_resp     <= '0;
                        r_c0_ready <= ~r_grant;
                        r_c1_ready <= r_grant;
                        r_c0_err   <= ~r_grant;
                        r_c1_err   <= r_grant;
                        r_mem_vld  <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_c0_ready   <= 1'b0;
                    r_c1_ready   <= 1'b0;
                    r_c0_err     <= 1'b0;
                    r_c1_err     <= 1'b0;
                    r_last_grant <= r_grant;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign arb2mem_valid = r_mem_vld;
    assign arb2mem_rw    = r_rw;
    assign arb2mem_addr  = r_addr;
    assign arb2mem_data  = r_wdata;
    assign c0_rdata      = r_resp;
    assign c1_rdata      = r_resp;
    assign c0_ready      = r_c0_ready;
    assign c1_ready      = r_c1_ready;
    assign c0_err        = r_c0_err;
    assign c1_err        = r_c1_err;
    assign busy          = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected bus and response entries.
// Latency: checks ISSUE-cycle counts per transaction and the ready/err/rdata of every completion.
// Backpressure: client drivers hold valid until ready; a memory model answers after a set latency.
module tb_mem_arbiter;

    localparam int TO = 4;

    typedef struct packed {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic         mutate;
    } req_t;

    typedef struct packed {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [7:0]   lat;
        logic [7:0]   len;
        logic [127:0] rdata;
    } bus_t;

    typedef struct packed {
        logic         id;
        logic         err;
        logic         chk_data;
        logic [127:0] rdata;
    } resp_t;

    logic         clk;
    logic         r;
    logic         cv   [2];
    logic         crw  [2];
    logic [31:0]  ca   [2];
    logic [127:0] cw   [2];
    logic [127:0] crd  [2];
    logic         crdy [2];
    logic         cerr [2];
    logic         arb2mem_valid;
    logic         arb2mem_rw;
    logic [31:0]  arb2mem_addr;
    logic [127:0] arb2mem_data;
    logic [127:0] mem2arb_data;
    logic         mem2arb_ready;
    logic         busy;

    req_t  cq [2][$];
    bus_t  bus_q[$];
    resp_t exp_q[$];
    logic  act  [2];
    logic  seen [2];
    logic  in_txn;
    int    mcnt;
    int    errors;
    int    checks;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .r(r),
        .c0_valid(cv[0]), .c0_rw(crw[0]), .c0_addr(ca[0]), .c0_wdata(cw[0]),
        .c0_rdata(crd[0]), .c0_ready(crdy[0]), .c0_err(cerr[0]),
        .c1_valid(cv[1]), .c1_rw(crw[1]), .c1_addr(ca[1]), .c1_wdata(cw[1]),
        .c1_rdata(crd[1]), .c1_ready(crdy[1]), .c1_err(cerr[1]),
        .arb2mem_valid(arb2mem_valid), .arb2mem_rw(arb2mem_rw),
        .arb2mem_addr(arb2mem_addr), .arb2mem_data(arb2mem_data),
        .mem2arb_data(mem2arb_data), .mem2arb_ready(mem2arb_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    // Queue one request: client stimulus, expected bus transaction and expected response.
    task automatic issue(input logic id, input logic rw, input logic [31:0] addr,
                         input logic [127:0] wdata, input logic mutate,
                         input int lat, input logic [127:0] mdata,
                         input logic exp_err, input int exp_len, input logic chk_data);
        req_t  q;
        bus_t  b;
        resp_t e;
        q = '{rw: rw, addr: addr, wdata: wdata, mutate: mutate};
        b = '{rw: rw, addr: addr, data: wdata, lat: 8'(lat), len: 8'(exp_len), rdata: mdata};
        e = '{id: id, err: exp_err, chk_data: chk_data, rdata: exp_err ? 128'h0 : mdata};
        bus_q.push_back(b);
        exp_q.push_back(e);
        cq[id].push_back(q);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(cq[0].size() == 0 && cq[1].size() == 0 && !act[0] && !act[1] &&
                 exp_q.size() == 0 && bus_q.size() == 0 && !busy && !in_txn) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk({name, "_drain_timeout"}, 128'(n), 128'd0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        r = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        r = 1'b1;
    endtask

    // Client drivers: load a request after a rising edge, retire it after its ready pulse.
    initial begin
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0; crw[i] = 1'b0; ca[i] = '0; cw[i] = '0;
            act[i] = 1'b0; seen[i] = 1'b0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (act[i] && seen[i]) begin
                    void'(cq[i].pop_front());
                    act[i] = 1'b0; seen[i] = 1'b0; cv[i] = 1'b0;
                end
                if (!act[i] && cq[i].size() > 0 && r) begin
                    crw[i] = cq[i][0].rw;
                    ca[i]  = cq[i][0].addr;
                    cw[i]  = cq[i][0].wdata;
                    cv[i]  = 1'b1;
                    act[i] = 1'b1;
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (cv[i] && crdy[i]) seen[i] = 1'b1;
                // Scramble the write line while granted: the arbiter must use its latched copy.
                if (cv[i] && act[i] && cq[i].size() > 0 && cq[i][0].mutate && arb2mem_valid)
                    cw[i] = ~cw[i];
            end
        end
    end

    // Memory model and bus checker.
    initial begin
        bus_t cur;
        logic have;
        mem2arb_ready = 1'b0;
        mem2arb_data  = '0;
        in_txn = 1'b0;
        mcnt   = 0;
        have   = 1'b0;
        cur    = '0;
        forever begin
            @(negedge clk);
            if (arb2mem_valid) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    mcnt   = 0;
                    have   = (bus_q.size() > 0);
                    if (have) cur = bus_q[0];
                    else chk("bus_unexpected_txn", 128'd1, 128'd0);
                end
                mcnt++;
                if (have) begin
                    chk("bus_rw",   128'(arb2mem_rw),   128'(cur.rw));
                    chk("bus_addr", 128'(arb2mem_addr), 128'(cur.addr));
                    chk("bus_data", arb2mem_data,       cur.data);
                    mem2arb_ready = (cur.lat != 0) && (mcnt == int'(cur.lat));
                    mem2arb_data  = cur.rdata;
                end
            end else begin
                mem2arb_ready = 1'b0;
                if (in_txn) begin
                    if (have) begin
                        chk("bus_issue_cycles", 128'(mcnt), 128'(cur.len));
                        void'(bus_q.pop_front());
                    end
                    in_txn = 1'b0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (crdy[0] || crdy[1]) begin
                chk("ready_onehot", 128'(crdy[0] & crdy[1]), 128'd0);
                if (exp_q.size() == 0) begin
                    chk("ready_unexpected", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_client", 128'(crdy[1]), 128'(e.id));
                    chk("resp_err", 128'(cerr[e.id]), 128'(e.err));
                    chk("other_err", 128'(cerr[~e.id]), 128'd0);
                    if (e.chk_data) chk("resp_rdata", crd[e.id], e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "global timeout");
    end

    localparam logic [127:0] D_F0  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66F0;
    localparam logic [127:0] D_WB  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] D_A   = 128'hAAAA_0000_0000_0000_0000_0000_0000_00A1;
    localparam logic [127:0] D_B   = 128'hBBBB_0000_0000_0000_0000_0000_0000_00B2;

    initial begin
        int n;
        errors = 0;
        checks = 0;
        r = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state.
        chk("rst_c0_ready", 128'(crdy[0]), 128'd0);
        chk("rst_c1_ready", 128'(crdy[1]), 128'd0);
        chk("rst_c0_err", 128'(cerr[0]), 128'd0);
        chk("rst_c1_err", 128'(cerr[1]), 128'd0);
        chk("rst_mem_valid", 128'(arb2mem_valid), 128'd0);
        chk("rst_mem_rw", 128'(arb2mem_rw), 128'd0);
        chk("rst_mem_addr", 128'(arb2mem_addr), 128'd0);
        chk("rst_mem_data", arb2mem_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rdata", crd[0], 128'd0);
        #2;
        r = 1'b1;

        // Single read, memory ready on the 2nd ISSUE cycle.
        issue(1'b0, 1'b0, 32'h0000_4010, 128'h0, 1'b0, 2, D_F0, 1'b0, 2, 1'b1);
        wait_idle("single_read");

        // Simultaneous requests right after reset: c0 first, then c1; repeat.
        do_reset();
        issue(1'b0, 1'b0, 32'h0000_1000, 128'h0, 1'b0, 1, D_A, 1'b0, 1, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_2000, 128'h0, 1'b0, 1, D_B, 1'b0, 1, 1'b1);
        wait_idle("tie_1");
        issue(1'b0, 1'b0, 32'h0000_1040, 128'h0, 1'b0, 2, D_B, 1'b0, 2, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_2040, 128'h0, 1'b0, 1, D_A, 1'b0, 1, 1'b1);
        wait_idle("tie_2");

        // Fairness: both clients continuously requesting -> 0,1,0,1.
        issue(1'b0, 1'b0, 32'h0000_3000, 128'h0, 1'b0, 1, D_A, 1'b0, 1, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_3100, 128'h0, 1'b0, 3, D_B, 1'b0, 3, 1'b1);
        issue(1'b0, 1'b1, 32'h0000_3200, D_A, 1'b0, 1, D_F0, 1'b0, 1, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_3300, 128'h0, 1'b0, 2, D_F0, 1'b0, 2, 1'b1);
        wait_idle("fairness");

        // Write-back with the client scrambling wdata during ISSUE.
        issue(1'b1, 1'b1, 32'h1234_5670, D_WB, 1'b1, 3, D_A, 1'b0, 3, 1'b0);
        wait_idle("writeback");

        // Timeout: memory silent -> 4 ISSUE cycles, err=1, rdata=0.
        issue(1'b0, 1'b0, 32'h0000_5000, 128'h0, 1'b0, 0, D_A, 1'b1, TO, 1'b1);
        wait_idle("timeout");
        // Ready on the last allowed cycle wins over the timeout.
        issue(1'b0, 1'b0, 32'h0000_5010, 128'h0, 1'b0, TO, D_B, 1'b0, TO, 1'b1);
        wait_idle("timeout_boundary");

        // Reset during ISSUE: bus drops at once, no ready for the abandoned request.
        bus_q.push_back('{rw: 1'b0, addr: 32'h0000_6000, data: 128'h0, lat: 8'd0, len: 8'd2, rdata: D_A});
        cq[0].push_back('{rw: 1'b0, addr: 32'h0000_6000, wdata: 128'h0, mutate: 1'b0});
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!(arb2mem_valid && mcnt >= 2) && n < 50);
        if (n >= 50) chk("rst_issue_wait_timeout", 128'(n), 128'd0);
        r = 1'b0;
        #1;
        chk("midrst_mem_valid", 128'(arb2mem_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_c0_ready", 128'(crdy[0]), 128'd0);
        cq[0].delete();
        cv[0] = 1'b0; act[0] = 1'b0; seen[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        r = 1'b1;
        issue(1'b1, 1'b0, 32'h0000_7000, 128'h0, 1'b0, 1, D_F0, 1'b0, 1, 1'b1);
        wait_idle("after_reset");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
